bus_reg_responder: RTL and testbench

- Target end of the pfs bus: arbitrates read and write requests from N_MASTERS bus masters (cmd_to_bus-style initiators) and grants them one at a time.
- Owns a register file of 2^ADDR_W words.
- Writes commit on grant; reads return a full row of words on the shared rd_data bus on the cycle after the grant.
- Register contents are also driven out flat for fabric control logic.

---
 rtl/bus_reg_responder.sv | 169 ++++++++++++++++
 tb/tb_bus_reg_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_reg_responder.sv
// Register-file target of the pfs bus: arbitrates per-master read/write requests and serves one per ARB/GRANT pair.
// Define BUS_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module bus_reg_responder #(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned ROW_BITS  = 2,
    parameter int unsigned DATA_W    = 16,
    localparam int unsigned RD_ADDR_W = ADDR_W - ROW_BITS
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [N_MASTERS-1:0]               wr_req,
    input  logic [N_MASTERS*ADDR_W-1:0]        wr_addr,
    input  logic [N_MASTERS*DATA_W-1:0]        wr_data,
    output logic [N_MASTERS-1:0]               wr_gnt,
    input  logic [N_MASTERS-1:0]               rd_req,
    input  logic [N_MASTERS*RD_ADDR_W-1:0]     rd_addr,
    output logic [N_MASTERS-1:0]               rd_gnt,
    output logic [(2**ROW_BITS)*DATA_W-1:0]    rd_data,
    output logic [(2**ADDR_W)*DATA_W-1:0]      regs_out
);

    localparam int unsigned IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned N_REGS = 2**ADDR_W;
    localparam int unsigned N_ROWS = 2**ROW_BITS;

    typedef enum logic {ARB, GRANT} state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           win_q, win_d;
    logic                       rd_kind_q, rd_kind_d;
    logic [DATA_W-1:0]          regs_q [N_REGS];
    logic [DATA_W-1:0]          regs_d [N_REGS];
    logic [N_ROWS*DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [N_MASTERS-1:0]       elig;
    logic                       found;
    logic [IDX_W-1:0]           pick;

    logic [ADDR_W-1:0]          wr_addr_w;
    logic [DATA_W-1:0]          wr_data_w;
    logic [RD_ADDR_W-1:0]       rd_addr_w;
    logic [ADDR_W-1:0]          rd_regno;

    assign elig = rd_req | wr_req;

`ifdef BUS_RR_ARB_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    int unsigned      idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            idx = (int unsigned'(ptr_q) + i) % N_MASTERS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB && found)
            ptr_d = IDX_W'((int unsigned'(pick) + 1) % N_MASTERS);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`else
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (!found && elig[i]) begin
                found = 1'b1;
                pick  = IDX_W'(i);
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB;
            win_q     <= '0;
            rd_kind_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rd_kind_q <= rd_kind_d;
        end
    end

    // Next state: winner and kind are latched only in ARB
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rd_kind_d = rd_kind_q;
        case (state_q)
            ARB: begin
                if (found) begin
                    state_d   = GRANT;
                    win_d     = pick;
                    rd_kind_d = rd_req[pick];
                end
            end
            GRANT:   state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        wr_gnt = '0;
        rd_gnt = '0;
        if (state_q == GRANT) begin
            if (rd_kind_q) rd_gnt[win_q] = 1'b1;
            else           wr_gnt[win_q] = 1'b1;
        end
    end

    always_comb begin
        wr_addr_w = wr_addr[win_q*ADDR_W +: ADDR_W];
        wr_data_w = wr_data[win_q*DATA_W +: DATA_W];
        rd_addr_w = rd_addr[win_q*RD_ADDR_W +: RD_ADDR_W];
    end

    // Transaction commits on the edge that ends GRANT
    always_comb begin
        regs_d    = regs_q;
        rd_data_d = rd_data_q;
        rd_regno  = '0;
        if (state_q == GRANT) begin
            if (rd_kind_q) begin
                for (int unsigned k = 0; k < N_ROWS; k++) begin
                    rd_regno = ADDR_W'(k << RD_ADDR_W) | ADDR_W'(rd_addr_w);
                    rd_data_d[k*DATA_W +: DATA_W] = regs_q[rd_regno];
                end
            end else begin
                regs_d[wr_addr_w] = wr_data_w;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
            for (int unsigned i = 0; i < N_REGS; i++) regs_q[i] <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            for (int unsigned i = 0; i < N_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign rd_data = rd_data_q;

    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < N_REGS; i++)
            regs_out[i*DATA_W +: DATA_W] = regs_q[i];
    end

endmodule

// File: tb/tb_bus_reg_responder.sv
// Directed self-checking bench for bus_reg_responder (default parameters).
// Contention expectations follow BUS_RR_ARB_EN when defined for the build.
module tb_bus_reg_responder;

    localparam int unsigned N   = 4;
    localparam int unsigned AW  = 8;
    localparam int unsigned RB  = 2;
    localparam int unsigned DW  = 16;
    localparam int unsigned RAW = AW - RB;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [N-1:0]           wr_req;
    logic [N*AW-1:0]        wr_addr;
    logic [N*DW-1:0]        wr_data;
    logic [N-1:0]           wr_gnt;
    logic [N-1:0]           rd_req;
    logic [N*RAW-1:0]       rd_addr;
    logic [N-1:0]           rd_gnt;
    logic [(2**RB)*DW-1:0]  rd_data;
    logic [(2**AW)*DW-1:0]  regs_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    bus_reg_responder #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .ROW_BITS  (RB),
        .DATA_W    (DW)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_data  (rd_data),
        .regs_out (regs_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] reg_word(input int unsigned r);
        return regs_out[r*DW +: DW];
    endfunction

    // Called at a negedge with the DUT in ARB; returns at the negedge after commit.
    task automatic do_write(input int unsigned m, input int unsigned a, input int unsigned d);
        bit got_gnt = 0;
        wr_addr[m*AW +: AW] = AW'(a);
        wr_data[m*DW +: DW] = DW'(d);
        wr_req[m] = 1'b1;
        for (int i = 0; i < 10 && !got_gnt; i++) begin
            @(negedge clock);
            if (wr_gnt[m]) got_gnt = 1;
        end
        check("wr_grant_seen", 64'(got_gnt), 64'd1);
        wr_req[m] = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_read(input int unsigned m, input int unsigned a);
        bit got_gnt = 0;
        rd_addr[m*RAW +: RAW] = RAW'(a);
        rd_req[m] = 1'b1;
        for (int i = 0; i < 10 && !got_gnt; i++) begin
            @(negedge clock);
            if (rd_gnt[m]) got_gnt = 1;
        end
        check("rd_grant_seen", 64'(got_gnt), 64'd1);
        rd_req[m] = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] base;
        logic [N-1:0] exp_seq [12];

        reset_n = 1'b0;
        wr_req  = '0;
        rd_req  = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (2) @(negedge clock);
        check("rst_wr_gnt",  64'(wr_gnt), 64'd0);
        check("rst_rd_gnt",  64'(rd_gnt), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_reg5",    64'(reg_word(5)), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // single write, exact timing
        wr_addr[0 +: AW] = 8'h05;
        wr_data[0 +: DW] = 16'hBEEF;
        wr_req[0] = 1'b1;
        @(negedge clock);
        check("wr1_gnt",        64'(wr_gnt), 64'b0001);
        check("wr1_no_rd_gnt",  64'(rd_gnt), 64'd0);
        check("wr1_reg5_before", 64'(reg_word(5)), 64'd0);
        wr_req[0] = 1'b0;
        @(negedge clock);
        check("wr1_gnt_pulse",  64'(wr_gnt), 64'd0);
        check("wr1_reg5",       64'(reg_word(5)), 64'hBEEF);
        check("wr1_rd_gnt",     64'(rd_gnt), 64'd0);

        // row read
        do_write(1, 8'h03, 16'h1111);
        do_write(2, 8'h43, 16'h2222);
        do_write(3, 8'h83, 16'h3333);
        do_write(0, 8'hC3, 16'h4444);
        rd_addr[2*RAW +: RAW] = 6'h03;
        rd_req[2] = 1'b1;
        @(negedge clock);
        check("row_rd_gnt", 64'(rd_gnt), 64'b0100);
        check("row_wr_gnt", 64'(wr_gnt), 64'd0);
        rd_req[2] = 1'b0;
        @(negedge clock);
        check("row_rd_gnt_pulse", 64'(rd_gnt), 64'd0);
        check("row_rd_data", rd_data, 64'h4444_3333_2222_1111);
        repeat (3) @(negedge clock);
        check("row_rd_hold", rd_data, 64'h4444_3333_2222_1111);

        // read-after-write, then hold across a write to the same register
        do_write(3, 8'h00, 16'hA5A5);
        do_read(1, 0);
        check("raw_rd_data", rd_data, 64'h0000_0000_0000_A5A5);
        do_write(2, 8'h00, 16'h0000);
        check("hold_reg0",    64'(reg_word(0)), 64'd0);
        check("hold_rd_data", rd_data, 64'h0000_0000_0000_A5A5);

        // simultaneous read+write from one master: read wins, write stays pending
        rd_addr[1*RAW +: RAW] = 6'h05;
        wr_addr[1*AW +: AW]   = 8'h22;
        wr_data[1*DW +: DW]   = 16'h7777;
        rd_req[1] = 1'b1;
        wr_req[1] = 1'b1;
        @(negedge clock);
        check("both_rd_gnt", 64'(rd_gnt), 64'b0010);
        check("both_wr_gnt", 64'(wr_gnt), 64'd0);
        rd_req[1] = 1'b0;
        @(negedge clock);
        check("both_rd_data", rd_data, 64'h0000_0000_0000_BEEF);
        @(negedge clock);
        check("both_wr_later", 64'(wr_gnt), 64'b0010);
        wr_req[1] = 1'b0;
        @(negedge clock);
        check("both_reg22", 64'(reg_word(8'h22)), 64'h7777);

        // reset asserted during a write GRANT
        wr_addr[0 +: AW] = 8'h10;
        wr_data[0 +: DW] = 16'h1234;
        wr_req[0] = 1'b1;
        @(negedge clock);
        check("mid_wr_gnt", 64'(wr_gnt), 64'b0001);
        reset_n = 1'b0;
        #1;
        check("mid_gnt_drop", 64'(wr_gnt), 64'd0);
        check("mid_rd_data",  rd_data, 64'd0);
        wr_req[0] = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_reg10",   64'(reg_word(8'h10)), 64'd0);
        check("mid_reg22",   64'(reg_word(8'h22)), 64'd0);
        check("mid_rd_data_after", rd_data, 64'd0);

        // contention (pointer freshly reset)
`ifdef BUS_RR_ARB_EN
        base = 4'b1011;
        exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000,
                    4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
`else
        base = 4'b0011;
        exp_seq = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000,
                    4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
`endif
        rd_req = base;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check($sformatf("cont_%0d", i), 64'(rd_gnt), 64'(exp_seq[i]));
            rd_req = base & ~rd_gnt;
        end
        // master 0 goes idle: master 1 now wins
        rd_req = 4'b0010;
        @(negedge clock);
        check("cont_m1_idle0", 64'(rd_gnt), 64'b0010);
        rd_req = '0;
        @(negedge clock);
        check("cont_quiet", 64'(rd_gnt), 64'd0);

        // re-issued write after the aborted one
        do_write(0, 8'h10, 16'h1234);
        check("reissue_reg10", 64'(reg_word(8'h10)), 64'h1234);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
